// File: rtl/char_render_if.sv
// Pixel-stream bundle between the text components and the char_render back-end.
// The master side also hosts the synchronous font ROM, so it drives font_data.
// No handshake: one pixel per px_clk, the stream never stalls.
interface char_render_if;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        hsync;
  logic        vsync;
  logic        activevideo;
  logic [7:0]  din_char;
  logic [2:0]  din_color;
  logic        din_n2d;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [2:0]  rgb;
  logic        hsync_o;
  logic        vsync_o;
  logic        activevideo_o;

  modport master (
    output x, y, hsync, vsync, activevideo, din_char, din_color, din_n2d, font_data,
    input  font_addr, rgb, hsync_o, vsync_o, activevideo_o
  );

  modport slave (
    input  x, y, hsync, vsync, activevideo, din_char, din_color, din_n2d, font_data,
    output font_addr, rgb, hsync_o, vsync_o, activevideo_o
  );
endinterface

// File: rtl/char_render.sv
// Purpose: hex-nibble translation, 8x8 font ROM lookup and glyph-row serialisation to rgb.
// Latency: x/y/sync/av at cycle T -> rgb/hsync_o/vsync_o/activevideo_o at T+4.
// Backpressure: none; continuous one-pixel-per-cycle stream. Optional blink: BLINK_EN.
module char_render #(
  parameter int          ZOOM = 0,
  parameter logic [2:0]  BG   = 3'b000
) (
  input  logic   px_clk,
  input  logic   rst,
  char_render_if.slave pix
);

  // Font column/row of the current pixel, wrapped to the 8x8 cell.
  logic [2:0] col_c, row_c;
  assign col_c = 3'(pix.x >> ZOOM);
  assign row_c = 3'(pix.y >> ZOOM);

  // S0: x/y-derived fields waiting one cycle for the component outputs.
  logic [2:0] col0, row0;
  // S1/S2: per-pixel attributes travelling alongside the ROM access.
  logic [2:0] col1, col2, color1, color2;
  // Sync and visible-area delay lines; bit 3 drives the outputs.
  logic [3:0] av_sr, hs_sr, vs_sr;

  // Hex nibble to ASCII '0'-'9' / 'A'-'F'; upper nibble ignored in that mode.
  logic [3:0] nib;
  logic [7:0] glyph, glyph_rom;
  assign nib   = pix.din_char[3:0];
  assign glyph = pix.din_n2d ? ((nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib}))
                             : pix.din_char;

`ifdef BLINK_EN
  // Bit 7 of a literal char is the blink attribute, not part of the glyph index.
  logic       blink_attr, blink1, blink2;
  logic [5:0] frame_cnt;
  assign blink_attr = ~pix.din_n2d & pix.din_char[7];
  assign glyph_rom  = {1'b0, glyph[6:0]};
`else
  assign glyph_rom  = glyph;
`endif

  // Sync/av delay lines; reset to the idle (inactive) levels.
  always_ff @(posedge px_clk) begin
    if (rst) begin
      av_sr <= 4'b0000;
      hs_sr <= 4'b1111;
      vs_sr <= 4'b1111;
    end else begin
      av_sr <= {av_sr[2:0], pix.activevideo};
      hs_sr <= {hs_sr[2:0], pix.hsync};
      vs_sr <= {vs_sr[2:0], pix.vsync};
    end
  end

  // S0 and S1: align x/y fields with din_*, then issue the ROM address.
  always_ff @(posedge px_clk) begin
    if (rst) begin
      col0          <= '0;
      row0          <= '0;
      col1          <= '0;
      color1        <= '0;
      pix.font_addr <= '0;
    end else begin
      col0          <= col_c;
      row0          <= row_c;
      col1          <= col0;
      color1        <= pix.din_color;
      pix.font_addr <= {glyph_rom, row0};
    end
  end

  // S2: carry column and color across the ROM read cycle.
  always_ff @(posedge px_clk) begin
    if (rst) begin
      col2   <= '0;
      color2 <= '0;
    end else begin
      col2   <= col1;
      color2 <= color1;
    end
  end

  // Glyph bit for this pixel; MSB of the row is the leftmost pixel.
  logic pix_bit;
`ifdef BLINK_EN
  assign pix_bit = pix.font_data[3'd7 - col2] & ~(blink2 & frame_cnt[5]);

  // Blink attribute pipeline and frame counter stepped at each vsync pulse start.
  always_ff @(posedge px_clk) begin
    if (rst) begin
      blink1    <= 1'b0;
      blink2    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      blink1 <= blink_attr;
      blink2 <= blink1;
      if (vs_sr[0] && !pix.vsync)
        frame_cnt <= frame_cnt + 6'd1;
    end
  end
`else
  assign pix_bit = pix.font_data[3'd7 - col2];
`endif

  // S3: final pixel color; blanked outside the visible area.
  always_ff @(posedge px_clk) begin
    if (rst)
      pix.rgb <= 3'b000;
    else
      pix.rgb <= !av_sr[2] ? 3'b000 : (pix_bit ? color2 : BG);
  end

  assign pix.hsync_o       = hs_sr[3];
  assign pix.vsync_o       = vs_sr[3];
  assign pix.activevideo_o = av_sr[3];

endmodule
